trap_entry_ctrl: RTL and testbench

Sequential trap-entry controller directly downstream of the exception detection unit. It captures the prioritized exception (code, PC, value) and resolves M/S delegation from `medeleg`. It then drives a single-cycle trap-write to the CSR file, holds the pipeline flushed, and issues a handshaked PC redirect to the trap vector. It owns the "one trap in flight" rule for the core.

---
 rtl/trap_entry_ctrl_pkg.sv | 38 +++
 rtl/trap_entry_ctrl_target_calc.sv | 27 ++
 rtl/trap_entry_ctrl.sv | 92 +++++++++
 tb/tb_trap_entry_ctrl.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/trap_entry_ctrl_pkg.sv
// rtl/trap_entry_ctrl_pkg.sv - privilege/cause encodings and FSM states for trap entry
`ifndef XLEN
`define XLEN 32
`endif

package trap_entry_ctrl_pkg;

    localparam logic [1:0] PRIV_U = 2'b00;
    localparam logic [1:0] PRIV_S = 2'b01;
    localparam logic [1:0] PRIV_M = 2'b11;

    localparam logic [4:0] CAUSE_MISALIGNED_FETCH    = 5'd0;
    localparam logic [4:0] CAUSE_FETCH_ACCESS        = 5'd1;
    localparam logic [4:0] CAUSE_ILLEGAL_INSTRUCTION = 5'd2;
    localparam logic [4:0] CAUSE_BREAKPOINT          = 5'd3;
    localparam logic [4:0] CAUSE_MISALIGNED_LOAD     = 5'd4;
    localparam logic [4:0] CAUSE_LOAD_ACCESS         = 5'd5;
    localparam logic [4:0] CAUSE_MISALIGNED_STORE    = 5'd6;
    localparam logic [4:0] CAUSE_STORE_ACCESS        = 5'd7;
    localparam logic [4:0] CAUSE_USER_ECALL          = 5'd8;
    localparam logic [4:0] CAUSE_SUPERVISOR_ECALL    = 5'd9;
    localparam logic [4:0] CAUSE_MACHINE_ECALL       = 5'd11;
    localparam logic [4:0] CAUSE_FETCH_PAGE_FAULT    = 5'd12;
    localparam logic [4:0] CAUSE_LOAD_PAGE_FAULT     = 5'd13;
    localparam logic [4:0] CAUSE_STORE_PAGE_FAULT    = 5'd15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CAPT  = 2'd1,
        ST_WRITE = 2'd2,
        ST_REDIR = 2'd3
    } trap_state_e;

    function automatic logic [1:0] target_priv(input logic to_s);
        return to_s ? PRIV_S : PRIV_M;
    endfunction

endpackage

// File: rtl/trap_entry_ctrl_target_calc.sv
// rtl/trap_entry_ctrl_target_calc.sv - combinational M/S delegation and trap vector base
module trap_target_calc
    import trap_entry_ctrl_pkg::*;
#(
    parameter int XLEN = `XLEN
) (
    input  logic [4:0]      cause,
    input  logic [1:0]      current_priv,
    input  logic [XLEN-1:0] medeleg,
    input  logic [XLEN-1:0] mtvec,
    input  logic [XLEN-1:0] stvec,
    output logic            to_s,
    output logic [1:0]      new_priv,
    output logic [XLEN-1:0] target_pc
);

    logic [XLEN-1:0] base;

    always_comb begin
        to_s      = (current_priv != PRIV_M) && medeleg[cause];
        new_priv  = target_priv(to_s);
        base      = to_s ? stvec : mtvec;
        // Exceptions always land on BASE; the MODE field is dropped, not decoded.
        target_pc = {base[XLEN-1:2], 2'b00};
    end

endmodule

// File: rtl/trap_entry_ctrl.sv
// rtl/trap_entry_ctrl.sv - trap-entry FSM: capture, CSR trap-write, flush, handshaked redirect
module trap_entry_ctrl
    import trap_entry_ctrl_pkg::*;
#(
    parameter int XLEN = `XLEN
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            exception,
    input  logic [4:0]      exception_code,
    input  logic [XLEN-1:0] exception_pc,
    input  logic [XLEN-1:0] exception_val,
    input  logic [1:0]      current_priv,
    input  logic [XLEN-1:0] medeleg,
    input  logic [XLEN-1:0] mtvec,
    input  logic [XLEN-1:0] stvec,
    output logic            trap_we,
    output logic            trap_to_s,
    output logic [4:0]      trap_cause,
    output logic [XLEN-1:0] trap_epc,
    output logic [XLEN-1:0] trap_tval,
    output logic [1:0]      trap_new_priv,
    output logic            flush,
    output logic            busy,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    input  logic            redirect_ready
);

    trap_state_e     state, state_next;
    logic            calc_to_s;
    logic [1:0]      calc_priv;
    logic [XLEN-1:0] calc_target;
    logic            capture;

    trap_target_calc #(.XLEN(XLEN)) u_target_calc (
        .cause        (exception_code),
        .current_priv (current_priv),
        .medeleg      (medeleg),
        .mtvec        (mtvec),
        .stvec        (stvec),
        .to_s         (calc_to_s),
        .new_priv     (calc_priv),
        .target_pc    (calc_target)
    );

    assign capture = (state == ST_IDLE) && exception;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Exceptions outside IDLE are dropped; the flush squashes them for refetch.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (exception) state_next = ST_CAPT;
            ST_CAPT:  state_next = ST_WRITE;
            ST_WRITE: state_next = ST_REDIR;
            ST_REDIR: if (redirect_ready) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            trap_to_s     <= 1'b0;
            trap_cause    <= '0;
            trap_epc      <= '0;
            trap_tval     <= '0;
            trap_new_priv <= '0;
            redirect_pc   <= '0;
        end else if (capture) begin
            trap_to_s     <= calc_to_s;
            trap_cause    <= exception_code;
            trap_epc      <= exception_pc;
            trap_tval     <= exception_val;
            trap_new_priv <= calc_priv;
            redirect_pc   <= calc_target;
        end
    end

    assign trap_we        = (state == ST_WRITE);
    assign redirect_valid = (state == ST_REDIR);
    assign busy           = (state != ST_IDLE);
    assign flush          = (state != ST_IDLE);

endmodule

// File: tb/tb_trap_entry_ctrl.sv
// tb/tb_trap_entry_ctrl.sv - directed and randomized trap sequences against a rule-level model
module tb_trap_entry_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        exception = 1'b0;
    logic [4:0]  exception_code = '0;
    logic [31:0] exception_pc = '0;
    logic [31:0] exception_val = '0;
    logic [1:0]  current_priv = '0;
    logic [31:0] medeleg = '0;
    logic [31:0] mtvec = '0;
    logic [31:0] stvec = '0;
    logic        trap_we, trap_to_s, flush, busy, redirect_valid;
    logic [4:0]  trap_cause;
    logic [31:0] trap_epc, trap_tval, redirect_pc;
    logic [1:0]  trap_new_priv;
    logic        redirect_ready = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    trap_entry_ctrl #(.XLEN(32)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .exception      (exception),
        .exception_code (exception_code),
        .exception_pc   (exception_pc),
        .exception_val  (exception_val),
        .current_priv   (current_priv),
        .medeleg        (medeleg),
        .mtvec          (mtvec),
        .stvec          (stvec),
        .trap_we        (trap_we),
        .trap_to_s      (trap_to_s),
        .trap_cause     (trap_cause),
        .trap_epc       (trap_epc),
        .trap_tval      (trap_tval),
        .trap_new_priv  (trap_new_priv),
        .flush          (flush),
        .busy           (busy),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .redirect_ready (redirect_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".outs"},
            {32'd0, trap_we, trap_to_s, trap_cause, trap_new_priv, flush, busy, redirect_valid},
            64'd0);
        chk({tag, ".epc"},  {32'd0, trap_epc},    64'd0);
        chk({tag, ".tval"}, {32'd0, trap_tval},   64'd0);
        chk({tag, ".rpc"},  {32'd0, redirect_pc}, 64'd0);
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge of the first idle cycle after.
    task automatic run_trap(input logic [4:0] code, input logic [31:0] pc, input logic [31:0] val,
                            input logic [1:0] priv, input logic [31:0] deleg,
                            input logic [31:0] mt, input logic [31:0] st,
                            input int delay, input bit busy_exc);
        bit          exp_s;
        logic [1:0]  exp_priv;
        logic [31:0] exp_pc;
        int          we_seen;
        exp_s    = (priv != 2'b11) && (((deleg >> code) & 32'd1) == 32'd1);
        exp_priv = exp_s ? 2'b01 : 2'b11;
        exp_pc   = (exp_s ? st : mt) & ~32'd3;
        we_seen  = 0;
        exception = 1'b1; exception_code = code; exception_pc = pc; exception_val = val;
        current_priv = priv; medeleg = deleg; mtvec = mt; stvec = st; redirect_ready = 1'b0;

        @(negedge clk);
        chk("capt.flush_busy", {62'd0, flush, busy}, 64'd3);
        chk("capt.we_rv", {62'd0, trap_we, redirect_valid}, 64'd0);
        if (busy_exc) begin
            exception_code = 5'd2; exception_pc = pc + 32'h40; exception_val = ~val;
            current_priv = 2'b00; medeleg = ~deleg; mtvec = st; stvec = mt;
        end else begin
            exception = 1'b0;
        end
        if (delay == 0) redirect_ready = 1'b1;

        @(negedge clk);
        if (trap_we) we_seen++;
        chk("write.we", {63'd0, trap_we}, 64'd1);
        chk("write.cause", {59'd0, trap_cause}, {59'd0, code});
        chk("write.epc", {32'd0, trap_epc}, {32'd0, pc});
        chk("write.tval", {32'd0, trap_tval}, {32'd0, val});
        chk("write.to_s", {63'd0, trap_to_s}, {63'd0, exp_s});
        chk("write.priv", {62'd0, trap_new_priv}, {62'd0, exp_priv});
        chk("write.rv", {63'd0, redirect_valid}, 64'd0);

        for (int i = 0; i <= delay; i++) begin
            @(negedge clk);
            if (trap_we) we_seen++;
            chk("redir.ctl", {61'd0, redirect_valid, flush, busy}, 64'd7);
            chk("redir.pc", {32'd0, redirect_pc}, {32'd0, exp_pc});
            chk("redir.cause", {59'd0, trap_cause}, {59'd0, code});
            if (i == delay) begin
                redirect_ready = 1'b1;
                exception = 1'b0;
            end
        end

        @(negedge clk);
        if (trap_we) we_seen++;
        chk("idle.ctl", {60'd0, redirect_valid, flush, busy, trap_we}, 64'd0);
        chk("we_count", we_seen, 64'd1);
        redirect_ready = 1'b0;
    endtask

    initial begin
        logic [1:0] privs [3];
        privs[0] = 2'b00; privs[1] = 2'b01; privs[2] = 2'b11;

        #2;
        chk_all_zero("reset");
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk_all_zero("post_reset");

        run_trap(5'd11, 32'h8000_0100, 32'h0, 2'b11, 32'hFFFF_FFFF, 32'h8000_0005, 32'h8020_0000, 0, 0);
        run_trap(5'd13, 32'h0000_4000, 32'h0000_1000, 2'b00, 32'h0000_2000, 32'h8000_0000, 32'h8020_0000, 1, 0);
        run_trap(5'd5, 32'h1234_5678, 32'hDEAD_BEEF, 2'b01, 32'h0, 32'h8000_0C01, 32'h8020_0000, 4, 0);
        run_trap(5'd8, 32'h0000_2000, 32'h0, 2'b00, 32'h0000_0100, 32'h8000_0000, 32'h8030_0002, 2, 1);
        run_trap(5'd9, 32'h0000_3000, 32'h77, 2'b01, 32'h0000_0200, 32'h8000_0100, 32'h8030_0000, 0, 0);

        exception = 1'b1; exception_code = 5'd7; exception_pc = 32'h4444; exception_val = 32'h55;
        current_priv = 2'b11; medeleg = 32'h0; mtvec = 32'h8000_0000;
        @(negedge clk);
        exception = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid.redir", {63'd0, redirect_valid}, 64'd1);
        #2 reset_n = 1'b0;
        #1 chk_all_zero("async_reset");
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("after_reset", {62'd0, trap_we, busy}, 64'd0);
        end

        for (int n = 0; n < 24; n++) begin
            run_trap(5'($urandom_range(0, 15)), $urandom, $urandom, privs[$urandom_range(0, 2)],
                     $urandom, $urandom, $urandom, int'($urandom_range(0, 4)), bit'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
